// File: rtl/uart_autobaud.sv
// uart_autobaud: measures the bit period of a 0x55 sync character on uart_rx and emits a UART divisor (bit period - 1).
// Define UART_AUTOBAUD_TOL_EN to also reject frames whose intervals 2..8 stray more than 25% from the first interval.
module uart_autobaud #(
    parameter int N_SYNC = 2,
    parameter int IV_W   = 17
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        arm,
    input  logic        uart_rx,
    output logic [15:0] div_out,
    output logic        div_vld,
    output logic        err,
    output logic        busy
);
    localparam int TOT_W  = IV_W + 3;
    localparam int TOT1_W = TOT_W + 1;
    localparam int BIT_W  = IV_W + 1;
    localparam logic [BIT_W-1:0] ONE_B = BIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_WAIT_START,
        S_MEASURE,
        S_STOP_CHK
    } state_t;

    state_t            state;
    logic [N_SYNC-1:0] sync_q;
    logic              rx_s;
    logic              rx_prev;
    logic              edge_det;
    logic [IV_W-1:0]   iv;
    logic [3:0]        hi_cnt;
    logic [3:0]        ne;
    logic [TOT_W-1:0]  total;
    logic [BIT_W-1:0]  bit_r;
    logic              stop_hi;

    logic [BIT_W-1:0]  ivl;
    logic [3:0]        k;
    logic [TOT_W-1:0]  total_nxt;
    logic [TOT1_W-1:0] sum_rnd;
    logic [BIT_W-1:0]  bit_calc;
    logic [BIT_W-1:0]  bit_q;
    logic [BIT_W-1:0]  stop_lo;
    logic [BIT_W:0]    stop_hi_lim;
    logic              pol_ok;
    logic              tol_bad;
    logic              range_bad;
    logic              stop_bad;
    logic              stop_done;
    logic              iv_sat;
    logic              abort;
    logic              finish;

    assign rx_s     = sync_q[N_SYNC-1];
    assign edge_det = rx_s ^ rx_prev;

    // Synchronizer, edge history and interval counter; iv restarts on every edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
            iv      <= '0;
        end else begin
            sync_q  <= {sync_q[N_SYNC-2:0], uart_rx};
            rx_prev <= rx_s;
            if (edge_det)
                iv <= '0;
            else if (!(&iv))
                iv <= iv + IV_W'(1);
        end
    end

    always_comb begin
        ivl         = {1'b0, iv} + ONE_B;
        k           = ne + 4'd1;
        total_nxt   = total + {2'b00, ivl};
        sum_rnd     = {1'b0, total_nxt} + TOT1_W'(4);
        bit_calc    = BIT_W'(sum_rnd >> 3);
        pol_ok      = (rx_s == k[0]);
        range_bad   = (bit_calc < BIT_W'(4)) || (32'(bit_calc) > 32'd65536);
        bit_q       = bit_r >> 2;
        stop_lo     = bit_r - bit_q;
        stop_hi_lim = {1'b0, bit_r} + {1'b0, bit_q};
        stop_bad    = !rx_s || (ivl < stop_lo) || ({1'b0, ivl} > stop_hi_lim);
        stop_done   = ({1'b0, iv} == bit_r - ONE_B);
        iv_sat      = &iv;
    end

`ifdef UART_AUTOBAUD_TOL_EN
    logic [BIT_W-1:0] iv0;
    logic [BIT_W-1:0] tol_diff;

    always_comb begin
        tol_diff = (ivl >= iv0) ? ivl - iv0 : iv0 - ivl;
        tol_bad  = (k != 4'd1) && (tol_diff > (iv0 >> 2));
    end
`else
    assign tol_bad = 1'b0;
`endif

    // A failing edge or a saturated interval both abort; the stop window ends on its bit-th clean cycle.
    always_comb begin
        abort  = 1'b0;
        finish = 1'b0;
        case (state)
            S_MEASURE: begin
                if (edge_det)
                    abort = !pol_ok || tol_bad || ((k == 4'd8) && range_bad);
                else
                    abort = iv_sat;
            end
            S_STOP_CHK: begin
                if (edge_det)
                    abort = stop_hi || stop_bad;
                else if (stop_hi && stop_done)
                    finish = 1'b1;
                else
                    abort = iv_sat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            hi_cnt  <= '0;
            ne      <= '0;
            total   <= '0;
            bit_r   <= '0;
            stop_hi <= 1'b0;
            div_out <= 16'd289;
            div_vld <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
`ifdef UART_AUTOBAUD_TOL_EN
            iv0     <= '0;
`endif
        end else begin
            div_vld <= 1'b0;
            err     <= 1'b0;
            if (!enable) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else if (arm) begin
                state  <= S_WAIT_IDLE;
                hi_cnt <= '0;
                busy   <= 1'b1;
            end else if (abort) begin
                state <= S_IDLE;
                err   <= 1'b1;
                busy  <= 1'b0;
            end else if (finish) begin
                state   <= S_IDLE;
                div_out <= 16'(bit_r - ONE_B);
                div_vld <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_WAIT_IDLE: begin
                        if (!rx_s)
                            hi_cnt <= '0;
                        else if (hi_cnt == 4'd15)
                            state <= S_WAIT_START;
                        else
                            hi_cnt <= hi_cnt + 4'd1;
                    end
                    S_WAIT_START: begin
                        if (edge_det && !rx_s) begin
                            state <= S_MEASURE;
                            total <= '0;
                            ne    <= '0;
                        end
                    end
                    S_MEASURE: begin
                        if (edge_det) begin
                            total <= total_nxt;
                            ne    <= k;
`ifdef UART_AUTOBAUD_TOL_EN
                            if (k == 4'd1)
                                iv0 <= ivl;
`endif
                            if (k == 4'd8) begin
                                bit_r   <= bit_calc;
                                stop_hi <= 1'b0;
                                state   <= S_STOP_CHK;
                            end
                        end
                    end
                    S_STOP_CHK: begin
                        if (edge_det)
                            stop_hi <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: directed and randomized 0x55 frames against a per-frame arithmetic prediction of uart_autobaud.
// IV_W is reduced to 12 so the saturation timeout stays short.
module tb_uart_autobaud;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        arm = 1'b0;
    logic        uart_rx = 1'b1;
    logic [15:0] div_out;
    logic        div_vld;
    logic        err;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    int n_vld = 0;
    int n_err = 0;
    int n_both = 0;
    int n_busy_bad = 0;
    logic busy_q = 1'b0;

    uart_autobaud #(.N_SYNC(2), .IV_W(12)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (enable),
        .arm     (arm),
        .uart_rx (uart_rx),
        .div_out (div_out),
        .div_vld (div_vld),
        .err     (err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters; busy must drop exactly with a div_vld/err pulse unless enable was pulled.
    always @(negedge clk) begin
        if (rstn) begin
            if (div_vld) n_vld++;
            if (err) n_err++;
            if (div_vld && err) n_both++;
            if ((div_vld || err) && busy) n_busy_bad++;
            if (busy_q && !busy && enable && !div_vld && !err) n_busy_bad++;
        end
        busy_q = busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed no completion expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the sync char yields intervals w[0..7] feeding the average, w[8] is the d7 width checked at stop.
    function automatic void predict(input int w[9], output bit ok, output int div);
        int total;
        int bitp;
        ok = 1'b1;
        total = 0;
        for (int i = 0; i < 8; i++) total += w[i];
`ifdef UART_AUTOBAUD_TOL_EN
        for (int i = 1; i < 8; i++) begin
            int d;
            d = (w[i] > w[0]) ? w[i] - w[0] : w[0] - w[i];
            if (d > (w[0] >> 2)) ok = 1'b0;
        end
`endif
        bitp = (total + 4) >> 3;
        if (bitp < 4) ok = 1'b0;
        if (w[8] < bitp - bitp / 4 || w[8] > bitp + bitp / 4) ok = 1'b0;
        div = bitp - 1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm_pulse();
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic send_frame(input int w[9]);
        for (int i = 0; i < 9; i++) begin
            uart_rx = (i % 2 == 1);
            repeat (w[i]) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
        idle(3);
    endtask

    task automatic run_case(input string tag, input int w[9]);
        bit eok;
        int ediv;
        int v0;
        int e0;
        int d0;
        predict(w, eok, ediv);
        v0 = n_vld;
        e0 = n_err;
        d0 = div_out;
        arm_pulse();
        idle(20);
        send_frame(w);
        idle(2 * (ediv + 1) + 40);
        wait_idle(tag);
        chk({tag, "_vld"}, n_vld - v0, eok ? 1 : 0);
        chk({tag, "_err"}, n_err - e0, eok ? 0 : 1);
        chk({tag, "_div"}, div_out, eok ? ediv : d0);
    endtask

    initial begin
        int w[9];
        int v0;
        int e0;
        int d0;
        int waited;

        enable = 1'b1;
        idle(4);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_div", div_out, 289);
        chk("rst_vld", div_vld, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        idle(10);
        chk("idle_busy", busy, 0);

        w = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
        run_case("b100", w);
        chk("b100_const", div_out, 99);

        w = '{100, 100, 100, 100, 140, 100, 100, 100, 100};
        run_case("d3s", w);
`ifdef UART_AUTOBAUD_TOL_EN
        chk("d3s_const", div_out, 99);
`else
        chk("d3s_const", div_out, 104);
`endif

        // Line held low after the start edge: iv must saturate at 2^12-1.
        v0 = n_vld;
        e0 = n_err;
        d0 = div_out;
        arm_pulse();
        idle(20);
        uart_rx = 1'b0;
        waited = 0;
        while (n_err == e0 && waited < 6000) begin
            @(negedge clk);
            waited++;
        end
        chk("tmo_err", n_err - e0, 1);
        chk("tmo_when", (waited >= 4090 && waited <= 4110), 1);
        chk("tmo_vld", n_vld - v0, 0);
        chk("tmo_div", div_out, d0);
        uart_rx = 1'b1;
        idle(30);

        w = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
        run_case("b3", w);
        w = '{4, 4, 4, 4, 4, 4, 4, 4, 4};
        run_case("b4", w);
        chk("b4_const", div_out, 3);

        // Reset in the middle of MEASURE.
        arm_pulse();
        idle(20);
        uart_rx = 1'b0;
        idle(50);
        uart_rx = 1'b1;
        idle(50);
        uart_rx = 1'b0;
        idle(20);
        rstn = 1'b0;
        idle(3);
        chk("mrst_busy", busy, 0);
        chk("mrst_div", div_out, 289);
        chk("mrst_err", err, 0);
        uart_rx = 1'b1;
        rstn = 1'b1;
        idle(5);
        chk("mrst_vld", div_vld, 0);
        w = '{50, 50, 50, 50, 50, 50, 50, 50, 50};
        run_case("b50", w);
        chk("b50_const", div_out, 49);

        // Re-arm mid-frame: restart without err, then a clean frame completes.
        v0 = n_vld;
        e0 = n_err;
        arm_pulse();
        idle(20);
        uart_rx = 1'b0;
        idle(40);
        uart_rx = 1'b1;
        idle(40);
        uart_rx = 1'b0;
        idle(40);
        arm_pulse();
        uart_rx = 1'b1;
        idle(30);
        chk("rearm_err", n_err - e0, 0);
        chk("rearm_busy", busy, 1);
        w = '{40, 40, 40, 40, 40, 40, 40, 40, 40};
        send_frame(w);
        idle(120);
        wait_idle("rearm");
        chk("rearm_vld", n_vld - v0, 1);
        chk("rearm_div", div_out, 39);
        chk("rearm_err2", n_err - e0, 0);

        // Dropping enable mid-frame returns to idle silently.
        v0 = n_vld;
        e0 = n_err;
        arm_pulse();
        idle(20);
        uart_rx = 1'b0;
        idle(30);
        enable = 1'b0;
        idle(3);
        chk("en_busy", busy, 0);
        enable = 1'b1;
        uart_rx = 1'b1;
        idle(10);
        chk("en_err", n_err - e0, 0);
        chk("en_vld", n_vld - v0, 0);

        for (int r = 0; r < 12; r++) begin
            int p;
            int j;
            int wr[9];
            p = int'($urandom_range(60, 4));
            j = p / 8;
            for (int i = 0; i < 9; i++) wr[i] = p - j + int'($urandom_range(2 * j, 0));
            if (r % 4 == 3) wr[$urandom_range(8, 1)] = p * 2;
            run_case("rnd", wr);
        end

        chk("never_both", n_both, 0);
        chk("busy_fall", n_busy_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Baud-rate detector that sits upstream of the UART receiver on the `uart_rx` pad line. When armed, it watches for a 0x55 sync character (8N1, LSB first), measures its bit period in `clk` cycles, and produces a divisor in UART `div` register format. Bit period = `div`+1 cycles. Software or the APB wrapper copies `div_out` into the UART `div` register when `div_vld` pulses. The block never drives the line; it only observes it.

## Interface
- `N_SYNC`, 2: synchronizer flops on `uart_rx`.
- `IV_W`, 17: interval counter width; an interval ≥ 2^IV_W−1 cycles is a timeout.
- `clk` in 1: sole clock.
- `rstn` in 1: reset, synchronous, active-low (sampled on `clk` rising edge).
- `enable` in 1: block enable; low forces IDLE.
- `arm` in 1: single-cycle pulse; starts or restarts a detection.
- `uart_rx` in 1: asynchronous serial line, idle high.
- `div_out` out 16: last successfully measured divisor.
- `div_vld` out 1: one-cycle pulse when `div_out` is updated.
- `err` out 1: one-cycle pulse when a detection is aborted.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `rx_s` is `uart_rx` after N_SYNC flops. Sync flops reset to 1.
- Edge = `rx_s` differs from its registered previous value.
- `iv` counts cycles since the last edge; it saturates at all-ones.
- States:
  - **IDLE**: leave on `arm && enable`, go to WAIT_IDLE.
  - **WAIT_IDLE**: wait until `rx_s`=1 for 16 consecutive cycles, then go to WAIT_START.
  - **WAIT_START**: a falling edge is edge 0. Clear `iv`, clear `total`, clear edge count `ne`, go to MEASURE.
  - **MEASURE**:
    - On each edge k=1..8, the interval is `iv`+1. Add it to `total` (20 bits) and set `ne`=k.
    - Interval 1 is latched as `iv0`.
    - Edge k must match the expected polarity: odd k rising, even k falling. A wrong polarity is an error.
    - After edge 8, compute `bit` = (`total`+4)>>3 and go to STOP_CHK.
  - **STOP_CHK**:
    - Expect rising edge 9 with interval within [`bit`−`bit`/4, `bit`+`bit`/4].
    - Then `rx_s` must stay 1 for `bit` cycles. Any edge in that window is an error.
    - On completion, go to DONE.
  - **DONE**: load `div_out` ← `bit`−1, pulse `div_vld`, go to IDLE.
  - **ERROR**: pulse `err`, go to IDLE. `div_out` is unchanged.
- Error causes:
  - `iv` saturates while in MEASURE or STOP_CHK.
  - Edge polarity mismatch.
  - `bit` < 4, or `bit`−1 > 16'hFFFF.
  - Tolerance violation (see Configuration).
- `arm` while busy: restart at WAIT_IDLE with no `err` pulse.
- `enable` low: return to IDLE next cycle with no pulse.
- `arm` and `enable` falling in the same cycle: `enable` wins.
- `div_vld` and `err` are never high in the same cycle.

## Timing
- Reset values:
  - `div_out` = 16'd289 (1e9/30/115200), `div_vld`=0, `err`=0, `busy`=0.
  - State IDLE, all counters 0.
- Edge detection latency from the pad is N_SYNC+1 cycles. This delay is constant, so intervals are unaffected.
- `div_vld` is high in the cycle after the last stop-high cycle, and `div_out` is valid in that same cycle.
- `err` is high in the cycle after the offending edge or saturation.
- `busy` rises the cycle after `arm` and falls in the same cycle as `div_vld` or `err`.
- Interval arithmetic is unsigned. `total` cannot overflow: at most 8×(2^17−1) < 2^20.

## Configuration
- `UART_AUTOBAUD_TOL_EN` defined:
  - In MEASURE, every interval k=2..8 must satisfy |interval−`iv0`| ≤ `iv0`>>2.
  - A violation goes to ERROR at that edge.
- Undefined:
  - No per-interval check; only polarity, timeout, range and stop checks apply.
  - The `iv0` register is removed.

## Test plan
- Reset, then idle: `div_out`=289, `div_vld`=0, `err`=0, `busy`=0.
- Arm; line idle 20 cycles, then 0x55 at 100 cycles/bit, then 200 high → single `div_vld` with `div_out`=99, `busy` low afterwards.
- 0x55 at 100 cycles/bit with d3 stretched to 140 → with TOL_EN: `err` at edge 5, `div_out` still 99. Without TOL_EN: `bit`=(840+4)>>3=105, `div_out`=104.
- Arm, then hold line low after edge 0 → `err` after 2^17−1 cycles, no `div_vld`.
- 0x55 at 3 cycles/bit (`bit`=3) → `err`, `div_out` unchanged. 0x55 at 4 cycles/bit → `div_out`=3.
- `rstn` low mid-MEASURE, then re-arm and send 0x55 at 50 cycles/bit → returns to reset values; a new detection yields `div_out`=49. A second `arm` mid-frame restarts with no `err`.
